// File: rtl/cpu_clk_pkg.sv
// Shared state encodings and widths for the CPU clock-enable controller.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_STEP = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam int unsigned CE_COUNT_W = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, level debouncer and press (0->1) pulse for a raw pushbutton.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned DB_W            = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
);

    localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            level_q;
    logic            pulse_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            pulse_q <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (s2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= s2_q;
                cnt_q   <= '0;
                pulse_q <= s2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign btn_level   = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: divided free-run, debounced single-step and halt freeze.
// Optional ce_count pulse counter is built when CPU_CLK_CE_COUNT_EN is defined.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIVISOR         = 4,
    parameter int unsigned DIV_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned DB_W            = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_mode,
    input  logic                  step_btn,
    input  logic                  halt,
    output logic                  cpu_ce,
    output logic [1:0]            state,
    output logic [CE_COUNT_W-1:0] ce_count
);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIVISOR - 1);

    logic             btn_level;
    logic             press_pulse;
    logic             step_pulse;
    logic             tick;
    logic             cpu_ce_q;
    logic [DIV_W-1:0] div_cnt_q;
    state_t           state_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (step_btn),
        .btn_level  (btn_level),
        .press_pulse(press_pulse)
    );

    // A press pulse only ever coincides with the newly accepted high level.
    assign step_pulse = press_pulse & btn_level;
    assign tick       = (div_cnt_q == DivLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_STEP;
            div_cnt_q <= '0;
            cpu_ce_q  <= 1'b0;
        end else begin
            cpu_ce_q <= ((state_q == S_RUN) && run_mode && !halt && tick) ||
                        ((state_q == S_STEP) && !run_mode && !halt && step_pulse);

            if (state_q == S_RUN) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
            end else begin
                div_cnt_q <= '0;
            end

            if (halt) begin
                state_q <= S_HALT;
            end else begin
                case (state_q)
                    S_STEP:  state_q <= run_mode ? S_RUN : S_STEP;
                    S_RUN:   state_q <= run_mode ? S_RUN : S_STEP;
                    S_HALT:  state_q <= run_mode ? S_RUN : S_STEP;
                    default: state_q <= S_STEP;
                endcase
            end
        end
    end

    assign cpu_ce = cpu_ce_q;
    assign state  = state_q;

`ifdef CPU_CLK_CE_COUNT_EN
    logic [CE_COUNT_W-1:0] ce_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_count_q <= '0;
        end else if (cpu_ce_q) begin
            ce_count_q <= ce_count_q + 1'b1;
        end
    end

    assign ce_count = ce_count_q;
`else
    assign ce_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (DIVISOR=4, DEBOUNCE_CYCLES=8).
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_mode;
    logic        step_btn;
    logic        halt;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [15:0] ce_count;

    int checks   = 0;
    int failures = 0;
    int n;

`ifdef CPU_CLK_CE_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    cpu_clk_ctrl #(
        .DIVISOR        (4),
        .DIV_W          (24),
        .DEBOUNCE_CYCLES(8),
        .DB_W           (20)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .run_mode(run_mode),
        .step_btn(step_btn),
        .halt    (halt),
        .cpu_ce  (cpu_ce),
        .state   (state),
        .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        return CntEn ? 32'(v) : 32'd0;
    endfunction

    // Advance one edge; outputs are sampled 1ns later and inputs then set for the next edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        step_btn = 1'b1;
        run_mode = 1'b1;
        halt     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step_clk();
            check("rst_ce", 32'(cpu_ce), 32'd0);
            check("rst_state", 32'(state), 32'd0);
            check("rst_count", 32'(ce_count), 32'd0);
        end
        rst = 1'b0;
        step_clk();
        check("rst_exit_state", 32'(state), 32'd1);
        step_btn = 1'b0;

        // Free run: one pulse every fourth edge after entering S_RUN.
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step_clk();
            check("run_ce", 32'(cpu_ce), 32'(i % 4 == 0));
            n += int'(cpu_ce);
        end
        check("run_pulses", 32'(n), 32'd10);
        step_clk();
        check("run_count", 32'(ce_count), exp_cnt(10));

        // Divider now at 2 -> 3; halt arrives on the tick edge.
        step_clk();
        step_clk();
        check("pre_halt_ce", 32'(cpu_ce), 32'd0);
        halt = 1'b1;
        step_clk();
        check("halt_tick_ce", 32'(cpu_ce), 32'd0);
        check("halt_state", 32'(state), 32'd2);

        run_mode = 1'b0;
        step_btn = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            n += int'(cpu_ce);
        end
        check("halt_step_pulses", 32'(n), 32'd0);
        check("halt_hold_state", 32'(state), 32'd2);
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) step_clk();
        halt = 1'b0;
        step_clk();
        check("unhalt_state", 32'(state), 32'd0);
        check("unhalt_count", 32'(ce_count), exp_cnt(10));

        // Single step: held button gives one pulse, in the cycle after edge 11.
        step_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step_clk();
            check("step_ce", 32'(cpu_ce), 32'(i == 11));
            check("step_level", 32'(u_dut.u_debounce.btn_level), 32'(i >= 10));
        end
        step_btn = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step_clk();
            n += int'(cpu_ce);
        end
        check("release_pulses", 32'(n), 32'd0);
        check("step_count", 32'(ce_count), exp_cnt(11));

        // Bounce: 5 high / 2 low never reaches 8 stable samples.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 7; i++) begin
                step_btn = (i < 5);
                step_clk();
                check("bounce_level", 32'(u_dut.u_debounce.btn_level), 32'd0);
                check("bounce_ce", 32'(cpu_ce), 32'd0);
            end
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            check("bounce_tail_ce", 32'(cpu_ce), 32'd0);
        end

        // Reset with debounce count at 6: progress is discarded.
        step_btn = 1'b1;
        for (int i = 0; i < 8; i++) step_clk();
        rst = 1'b1;
        step_clk();
        check("dbrst_ce", 32'(cpu_ce), 32'd0);
        check("dbrst_state", 32'(state), 32'd0);
        check("dbrst_count", 32'(ce_count), 32'd0);
        rst      = 1'b0;
        step_btn = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step_clk();
            n += int'(cpu_ce);
        end
        check("dbrst_no_pulse", 32'(n), 32'd0);
        step_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step_clk();
            check("dbrst_step_ce", 32'(cpu_ce), 32'(i == 11));
        end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) step_clk();
        check("dbrst_step_count", 32'(ce_count), exp_cnt(1));

        // Reset with divider at 2: next pulse needs a full interval.
        run_mode = 1'b1;
        step_clk();
        check("divrst_enter", 32'(state), 32'd1);
        step_clk();
        step_clk();
        rst = 1'b1;
        step_clk();
        check("divrst_state", 32'(state), 32'd0);
        check("divrst_ce", 32'(cpu_ce), 32'd0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step_clk();
            check("divrst_run_state", 32'(state), 32'd1);
            check("divrst_run_ce", 32'(cpu_ce), 32'(j == 5));
        end
        check("divrst_count", 32'(ce_count), exp_cnt(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
